// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache arbiter.
//   arb_state_t : arbiter FSM state encoding
//   grant_t     : which cache owns the memory port
//   ARB_ADDR_W / ARB_LINE_W : default address and cache-line widths
package arbiter_types;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/cache_arbiter_grant.sv
// Round-robin grant decision between the I-cache and the D-cache.
// Ports:
//   i_req, d_req : pending requests from each cache
//   last_grant   : requester served most recently
//   grant_valid  : at least one request is pending
//   grant        : requester to serve next
module arbiter_grant
    import arbiter_types::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  grant_t last_grant,
    output logic   grant_valid,
    output grant_t grant
);

    always_comb begin
        grant_valid = i_req | d_req;
        grant       = GRANT_I;
        if (i_req && d_req) begin
            // Contention: whoever did not win last time goes now.
            grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (d_req) begin
            grant = GRANT_D;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Shares the single physical-memory line port between the I-cache and the
// D-cache, one line transaction at a time, round-robin on contention.
// Ports:
//   clk, rst                          : clock, async active-high reset
//   i_read, i_address                 : I-cache line read request
//   i_rdata, i_resp                   : I-cache return data and done pulse
//   d_read, d_write, d_address, d_wdata : D-cache read / write-back request
//   d_rdata, d_resp                   : D-cache return data and done pulse
//   pmem_read, pmem_write, pmem_address, pmem_wdata : registered memory bus
//   pmem_rdata, pmem_resp             : memory return data and completion
//
// state  | meaning
// IDLE   | sampling requests, grant on the next edge
// I_BUSY | I-cache transaction outstanding on pmem
// D_BUSY | D-cache transaction outstanding on pmem
// DONE   | one-cycle turnaround so the served cache can drop its request
module cache_arbiter
    import arbiter_types::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int LINE_W = ARB_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t state, state_next;
    grant_t     last_grant;
    grant_t     grant;
    logic       grant_valid;
    logic       d_req;

    assign d_req = d_read | d_write;

    arbiter_grant u_grant (
        .i_req       (i_read),
        .d_req       (d_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = (grant == GRANT_I) ? I_BUSY : D_BUSY;
            I_BUSY:  if (pmem_resp)   state_next = DONE;
            D_BUSY:  if (pmem_resp)   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Responses go only to the cache that owns the transaction.
    always_comb begin
        i_resp = (state == I_BUSY) && pmem_resp;
        d_resp = (state == D_BUSY) && pmem_resp;
    end

    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    // Registered memory bus and round-robin history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            last_grant   <= GRANT_D;
        end else if (state == IDLE && grant_valid) begin
            last_grant <= grant;
            if (grant == GRANT_I) begin
                pmem_read    <= 1'b1;
                pmem_write   <= 1'b0;
                pmem_address <= i_address;
            end else begin
                // Read and write together is illegal; the write wins.
                pmem_read    <= ~d_write;
                pmem_write   <= d_write;
                pmem_address <= d_address;
                pmem_wdata   <= d_wdata;
            end
        end else if ((state == I_BUSY || state == D_BUSY) && pmem_resp) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
        end
    end

    a_no_d_read_and_write: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_address;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_address;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] LINE_DEAD = {8{32'hDEADBEEF}};
    localparam logic [255:0] LINE_1234 = {8{32'h12345678}};
    localparam logic [255:0] LINE_CAFE = {8{32'hCAFEF00D}};
    localparam logic [255:0] LINE_AAAA = {8{32'hAAAA5555}};

    always #5 clk = ~clk;

    cache_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        i_read     = 1'b0;
        i_address  = '0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_address  = '0;
        d_wdata    = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        check("rst_pmem_read",  pmem_read,    0);
        check("rst_pmem_write", pmem_write,   0);
        check("rst_pmem_addr",  pmem_address, 0);
        check("rst_pmem_wdata", pmem_wdata,   0);
        check("rst_i_resp",     i_resp,       0);
        check("rst_d_resp",     d_resp,       0);

        // I-only read
        i_read = 1'b1; i_address = 32'h60;
        tick();
        check("i_rd_strobe",  pmem_read,    1);
        check("i_rd_nowrite", pmem_write,   0);
        check("i_rd_addr",    pmem_address, 32'h60);
        tick();
        check("i_rd_hold",    pmem_read,    1);
        check("i_rd_no_resp", i_resp,       0);
        pmem_rdata = LINE_DEAD; pmem_resp = 1'b1;
        #1;
        check("i_rd_resp",    i_resp,  1);
        check("i_rd_d_quiet", d_resp,  0);
        check("i_rd_rdata",   i_rdata, LINE_DEAD);
        check("d_rdata_pass", d_rdata, LINE_DEAD);
        tick();
        // DONE: a lingering pmem_resp must not produce another pulse
        check("i_done_strobe", pmem_read, 0);
        check("i_done_resp",   i_resp,    0);
        check("i_done_dresp",  d_resp,    0);
        pmem_resp = 1'b0; i_read = 1'b0;
        tick();

        // D write-back
        d_write = 1'b1; d_address = 32'h100; d_wdata = LINE_1234;
        tick();
        check("d_wr_strobe", pmem_write,   1);
        check("d_wr_noread", pmem_read,    0);
        check("d_wr_addr",   pmem_address, 32'h100);
        check("d_wr_wdata",  pmem_wdata,   LINE_1234);
        tick();
        pmem_resp = 1'b1;
        #1;
        check("d_wr_resp",    d_resp, 1);
        check("d_wr_i_quiet", i_resp, 0);
        tick();
        pmem_resp = 1'b0; d_write = 1'b0;
        check("d_wr_clear",   pmem_write, 0);
        check("d_wr_one_pls", d_resp,     0);
        tick();

        // Simultaneous after reset: I first
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_wdata", pmem_wdata, 0);
        i_read = 1'b1; i_address = 32'h400;
        d_read = 1'b1; d_address = 32'h200; d_wdata = LINE_CAFE;
        tick();
        check("cont1_i_first", pmem_address, 32'h400);
        check("cont1_i_read",  pmem_read,    1);
        pmem_rdata = LINE_AAAA; pmem_resp = 1'b1;
        #1;
        check("cont1_i_resp", i_resp, 1);
        check("cont1_d_wait", d_resp, 0);
        tick();                                  // r+1: DONE
        pmem_resp = 1'b0; i_read = 1'b0;
        check("cont1_done_low", pmem_read, 0);
        tick();                                  // r+2: IDLE
        check("cont1_idle_low", pmem_read, 0);
        tick();                                  // r+3: D strobe
        check("cont1_d_read",  pmem_read,    1);
        check("cont1_d_addr",  pmem_address, 32'h200);
        check("cont1_d_wdata", pmem_wdata,   LINE_CAFE);

        // Address change while busy
        d_address = 32'h300;
        tick();
        check("busy_addr_hold", pmem_address, 32'h200);
        pmem_resp = 1'b1;
        #1;
        check("cont1_d_resp", d_resp, 1);
        tick();
        pmem_resp = 1'b0;
        i_read = 1'b1; i_address = 32'h500; d_address = 32'h600;
        tick();                                  // IDLE, both high, last = D
        tick();
        check("cont2_i_wins", pmem_address, 32'h500);
        pmem_resp = 1'b1;
        #1;
        check("cont2_i_resp", i_resp, 1);
        tick();
        pmem_resp = 1'b0;                        // both still high, last = I
        tick();
        tick();
        check("cont3_d_wins", pmem_address, 32'h600);
        check("cont3_d_read", pmem_read,    1);
        pmem_resp = 1'b1;
        #1;
        check("cont3_d_resp", d_resp, 1);
        check("cont3_i_none", i_resp, 0);
        tick();
        pmem_resp = 1'b0; d_read = 1'b0; i_read = 1'b0;
        tick();

        // Stale request held through DONE
        i_read = 1'b1; i_address = 32'h700;
        tick();
        check("stale_read",   pmem_read,  1);
        check("stale_wdata",  pmem_wdata, LINE_CAFE);
        pmem_resp = 1'b1;
        #1;
        check("stale_resp",   i_resp, 1);
        tick();                                  // DONE, i_read still high
        pmem_resp = 1'b0;
        check("stale_done",   pmem_read, 0);
        i_read = 1'b0;
        tick();
        check("stale_idle",   pmem_read, 0);
        tick();
        check("stale_no_new", pmem_read, 0);

        // Reset mid-operation
        i_read = 1'b1; i_address = 32'h800;
        tick();
        check("mid_read", pmem_read, 1);
        rst = 1'b1;
        #1;
        check("mid_async_drop", pmem_read, 0);
        check("mid_addr_clear", pmem_address, 0);
        i_read = 1'b0;
        tick();
        rst = 1'b0;
        pmem_resp = 1'b1;
        #1;
        check("late_i_resp", i_resp, 0);
        check("late_d_resp", d_resp, 0);
        tick();
        check("late_no_read",  pmem_read,  0);
        check("late_no_write", pmem_write, 0);
        check("late_i_resp2",  i_resp,     0);
        pmem_resp = 1'b0;
        d_write = 1'b1; d_address = 32'h900; d_wdata = LINE_1234;
        tick();
        check("post_rst_grant", pmem_write,   1);
        check("post_rst_addr",  pmem_address, 32'h900);
        d_write = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Shares the single 256-bit physical-memory port between the instruction cache and the data cache inside `mp3`. Accepts line-granularity requests from both caches, grants one at a time with round-robin priority, drives the registered `pmem_*` bus, and returns `pmem_resp` and `pmem_rdata` to the granted cache only. The `mp3` top-level `pmem_*` ports connect directly to this block.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width.
- `LINE_W`, 256, cache line width in bits.

Ports:
- `clk` in 1: system clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_read` in 1: I-cache line read request; level, held until `i_resp`.
- `i_address` in ADDR_W: I-cache line address; 32-byte aligned.
- `i_rdata` out LINE_W: line returned to I-cache.
- `i_resp` out 1: one-cycle completion pulse to I-cache.
- `d_read` in 1: D-cache line read request; level, held until `d_resp`.
- `d_write` in 1: D-cache write-back request; level, held until `d_resp`.
- `d_address` in ADDR_W: D-cache line address; 32-byte aligned.
- `d_wdata` in LINE_W: write-back line.
- `d_rdata` out LINE_W: line returned to D-cache.
- `d_resp` out 1: one-cycle completion pulse to D-cache.
- `pmem_read` out 1: physical-memory read strobe; registered.
- `pmem_write` out 1: physical-memory write strobe; registered.
- `pmem_address` out ADDR_W: registered address.
- `pmem_wdata` out LINE_W: registered write data.
- `pmem_rdata` in LINE_W: line from physical memory.
- `pmem_resp` in 1: physical-memory completion.

## Operation
- FSM states: `IDLE`, `I_BUSY`, `D_BUSY`, `DONE`.
- `IDLE` samples `i_read` and `d_read | d_write`:
  - Neither asserted: stay in `IDLE`.
  - One asserted: grant that requester.
  - Both asserted: grant the requester that is not `last_grant`.
- On grant, the edge latches `pmem_address` and `pmem_wdata` (D only), sets `pmem_read` or `pmem_write`, updates `last_grant`, and moves to `I_BUSY` or `D_BUSY`.
- I grant always issues a read, and `pmem_wdata` holds its previous value.
- `d_read` and `d_write` both asserted is illegal: an assertion fires, and the request is treated as a write.
- In `*_BUSY`, requester inputs are ignored. `pmem_*` outputs stay constant until `pmem_resp`.
- On `pmem_resp` in `I_BUSY`, `i_resp` = 1 combinationally in that cycle. `D_BUSY` does the same on `d_resp`. The next state is `DONE`, and `pmem_read`/`pmem_write` clear on that edge.
- `DONE` lasts exactly one cycle and ignores all requests, so the served cache can drop its stale request. It then moves to `IDLE`.
- `i_rdata` = `pmem_rdata` and `d_rdata` = `pmem_rdata` at all times, as pure pass-through. Caches qualify the data with their resp.
- `pmem_resp` in `IDLE` or `DONE` is ignored: no resp to either cache, and no state change.
- `last_grant` resets to D, so the first simultaneous contention goes to I.

## Timing
- Reset values: state `IDLE`, `last_grant` = D, `pmem_read` = 0, `pmem_write` = 0, `pmem_address` = 0, `pmem_wdata` = 0, `i_resp` = 0, `d_resp` = 0.
- Reset mid-transaction: the `pmem` strobe drops asynchronously and the transaction is abandoned. A late `pmem_resp` is ignored per the `IDLE` rule.
- Request-to-strobe latency: a request high in `IDLE` cycle t gives `pmem_read` or `pmem_write` high in cycle t+1.
- Response: `pmem_resp` in cycle r gives the cache resp in cycle r (0 added latency). The strobe is low in r+1 (`DONE`). `IDLE` occurs in r+2. The next grant's strobe appears in r+3.
- The gap between back-to-back transactions is therefore 2 cycles with the strobe low.
- `i_resp` and `d_resp` are never high in the same cycle. Each is high for exactly one cycle per transaction.

## Structure
- Shared package `arbiter_types`:
  - `arb_state_t` enum covering `IDLE`, `I_BUSY`, `D_BUSY`, `DONE`.
  - `grant_t` enum with values `GRANT_I` and `GRANT_D`.
  - The line-width and address-width localparams.
- One natural combinational sub-module, `arbiter_grant`, takes `i_req`, `d_req` and `last_grant`, and returns `grant_valid` and `grant`.
- FSM, output registers and the resp muxing live in `cache_arbiter`.

## Test plan
- **I-only read:** `i_read` = 1 with `i_address` = 0x0000_0060. Expected: `pmem_read` = 1 and `pmem_address` = 0x60 next cycle. Then memory responds with `pmem_rdata` = {8{32'hDEADBEEF}}: `i_resp` = 1 in the `pmem_resp` cycle, `i_rdata` matches, and `d_resp` stays 0.
- **D write-back:** `d_write` = 1 with `d_address` = 0x100 and `d_wdata` = {8{32'h1234_5678}}. Expected: `pmem_write` = 1, `pmem_address` = 0x100, `pmem_wdata` equal to the input, then `d_resp` pulses once and `pmem_write` = 0 the next cycle.
- **Simultaneous after reset:** `i_read` and `d_read` both high. Expected: I is served first. D is granted in the cycle after `DONE`, with `pmem_address` = D address. Repeat the contention and confirm the grants alternate.
- **Address change while busy:** change `d_address` from 0x200 to 0x300 during `D_BUSY`. Expected: `pmem_address` stays 0x200 until resp.
- **Stale request:** keep `i_read` high for one cycle after `i_resp`. Expected: no new `pmem_read` is issued from the `DONE` cycle, and only one I transaction completes.
- **Reset mid-op:** assert `rst` during `I_BUSY`. Expected: `pmem_read` = 0 immediately. A later spurious `pmem_resp` gives `i_resp` = 0 and `d_resp` = 0, and the state stays `IDLE`.
